// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, opcode classifiers.
// No timing of its own; types and pure functions only.
// No flow control here; users of the package handle the handshake.
package alu_pkg;

    localparam logic [3:0] OP_FWD = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_ROR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Opcodes above MUL are undefined and finish as a single-cycle op.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_MUL);
    endfunction

    // Shifts and rotate iterate once per bit of the shift amount.
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle unit: FWD/ADD/AND/OR/SUB with carry out.
// Zero latency; purely combinational.
// No backpressure; the enclosing FSM decides when the output is captured.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         carry
);

    logic [W:0] sum;

    // W+1 bit adder; SUB is A + ~B + 1 so the MSB reads as "no borrow".
    always_comb begin
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_FWD: res = b;
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                res   = sum[W-1:0];
                carry = sum[W];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                res   = sum[W-1:0];
                carry = sum[W];
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops, bit-serial shifts/rotate and shift-add multiply.
// Latency from accepting edge to done: 1 (single-cycle), k+1 (shift by k), W+1 (MUL).
// start is ignored while busy; no queuing, caller stalls on busy.
module seq_alu
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         start,
    input  logic [3:0]   operation,
    input  logic [W-1:0] data1,
    input  logic [W-1:0] data2,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         ZERO,
    output logic         CARRY,
    output logic         ILLEGAL
);

    localparam int SHW = $clog2(W);

    state_t       state;
    logic [3:0]   op_q;
    logic [W-1:0] opa;      // operand A / shift register / multiplicand
    logic [W-1:0] opb;      // operand B / multiplier
    logic [W-1:0] acc;      // multiply accumulator, overflow dropped
    logic [SHW:0] cnt;      // one extra bit so it can hold W for MUL

    logic [SHW:0] cnt_init;
    logic [W-1:0] core_res;
    logic         core_carry;
    logic [W-1:0] fin_res;
    logic         fin_carry;

    alu_core #(.W(W)) u_core (
        .op    (op_q),
        .a     (opa),
        .b     (opb),
        .res   (core_res),
        .carry (core_carry)
    );

    // Step count chosen at acceptance from the incoming opcode and shift amount.
    always_comb begin
        cnt_init = '0;
        if (is_shift_op(operation))
            cnt_init = {1'b0, data2[SHW-1:0]};
        else if (operation == OP_MUL)
            cnt_init = (SHW + 1)'(W);
    end

    // Final value selection once the iteration has run out.
    always_comb begin
        fin_res   = core_res;
        fin_carry = 1'b0;
        if (!is_legal_op(op_q))
            fin_res = '0;
        else if (is_shift_op(op_q))
            fin_res = opa;
        else if (op_q == OP_MUL)
            fin_res = acc;
        else if ((op_q == OP_ADD) || (op_q == OP_SUB))
            fin_carry = core_carry;
    end

    // FSM, iteration datapath and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ZERO    <= 1'b0;
            CARRY   <= 1'b0;
            ILLEGAL <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= operation;
                        opa   <= data1;
                        opb   <= data2;
                        acc   <= '0;
                        cnt   <= cnt_init;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - (SHW + 1)'(1);
                        case (op_q)
                            OP_SLL: opa <= {opa[W-2:0], 1'b0};
                            OP_SRL: opa <= {1'b0, opa[W-1:1]};
                            OP_SRA: opa <= {opa[W-1], opa[W-1:1]};
                            OP_ROR: opa <= {opa[0], opa[W-1:1]};
                            OP_MUL: begin
                                if (opb[0])
                                    acc <= acc + opa;
                                opa <= {opa[W-2:0], 1'b0};
                                opb <= {1'b0, opb[W-1:1]};
                            end
                            default: opa <= opa;
                        endcase
                    end else begin
                        result  <= fin_res;
                        ZERO    <= (fin_res == '0);
                        CARRY   <= fin_carry;
                        ILLEGAL <= !is_legal_op(op_q);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at W=8 and W=16 against an arithmetic reference model.
// Checks results, flags, latency, busy handshake, illegal opcodes and async reset.
// Every wait on done is bounded by a cycle budget.
module tb_seq_alu;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;

    logic        start8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, zero8, carry8, ill8;
    logic [7:0]  res8;

    logic        start16 = 1'b0;
    logic [3:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, zero16, carry16, ill16;
    logic [15:0] res16;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    seq_alu #(.W(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .start(start8), .operation(op8),
        .data1(a8), .data2(b8), .busy(busy8), .done(done8), .result(res8),
        .ZERO(zero8), .CARRY(carry8), .ILLEGAL(ill8)
    );

    seq_alu #(.W(16)) dut16 (
        .CLK(CLK), .RESET(RESET), .start(start16), .operation(op16),
        .data1(a16), .data2(b16), .busy(busy16), .done(done16), .result(res16),
        .ZERO(zero16), .CARRY(carry16), .ILLEGAL(ill16)
    );

    typedef struct {
        longint res;
        logic   z;
        logic   c;
        logic   ill;
        int     lat;
    } exp_t;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the opcode table, using plain integer arithmetic.
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input longint a, input longint b);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        int     k    = int'(b % w);
        longint sa;
        e.res = 0; e.c = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (op)
            4'd0: e.res = b;
            4'd1: begin e.res = (a + b) & mask; e.c = ((a + b) > mask); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: begin e.res = (a - b) & mask; e.c = (a >= b); end
            4'd5: begin e.res = (a << k) & mask; e.lat = k + 1; end
            4'd6: begin e.res = a >> k; e.lat = k + 1; end
            4'd7: begin
                sa = a[w-1] ? a - (longint'(1) << w) : a;
                e.res = (sa >>> k) & mask; e.lat = k + 1;
            end
            4'd8: begin e.res = ((a >> k) | (a << (w - k))) & mask; e.lat = k + 1; end
            4'd9: begin e.res = (a * b) & mask; e.lat = w + 1; end
            default: begin e.res = 0; e.ill = 1'b1; end
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // One complete transaction: accept, wait for done, compare everything.
    task automatic run_op(input int w, input logic [3:0] op, input longint a,
                          input longint b, input string tag);
        exp_t e;
        int   n = 0;
        logic got = 1'b0;
        e = model(w, op, a, b);
        @(negedge CLK);
        if (w == 8) begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else begin start16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
        @(posedge CLK); #1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = ~a8; b8 = ~b8; a16 = ~a16; b16 = ~b16;  // operands free after acceptance
        chk({tag, ".busy_hi"}, (w == 8) ? busy8 : busy16, 1);
        while (!got && n < 40) begin
            @(posedge CLK); #1;
            n++;
            if ((w == 8) ? done8 : done16) got = 1'b1;
        end
        chk({tag, ".lat"}, got ? n : -1, e.lat);
        chk({tag, ".res"}, (w == 8) ? longint'(res8) : longint'(res16), e.res);
        chk({tag, ".zero"}, (w == 8) ? zero8 : zero16, e.z);
        chk({tag, ".carry"}, (w == 8) ? carry8 : carry16, e.c);
        chk({tag, ".ill"}, (w == 8) ? ill8 : ill16, e.ill);
        chk({tag, ".busy_lo"}, (w == 8) ? busy8 : busy16, 0);
        @(posedge CLK); #1;
        chk({tag, ".done_pulse"}, (w == 8) ? done8 : done16, 0);
    endtask

    initial begin
        int  d1, d2, late;
        // Reset state
        #1;
        chk("rst.busy", busy8, 0);
        chk("rst.done", done8, 0);
        chk("rst.res", res8, 0);
        chk("rst.flags", {zero8, carry8, ill8}, 0);
        chk("rst.res16", res16, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RESET = 1'b0;

        // Directed W=8
        run_op(8, 4'b0001, 'hF0, 'h10, "add_wrap");
        run_op(8, 4'b0100, 'h05, 'h07, "sub_borrow");
        run_op(8, 4'b0111, 'h84, 3, "sra3");
        run_op(8, 4'b1000, 'h81, 1, "ror1");
        run_op(8, 4'b0101, 'h5A, 0, "sll0");
        run_op(8, 4'b1001, 13, 11, "mul13x11");
        run_op(8, 4'b1001, 'h10, 'h10, "mul_ovf");
        run_op(8, 4'b1011, 'h33, 'h44, "illegal");
        run_op(8, 4'b0010, 'hF3, 'h3C, "and_after_ill");
        run_op(8, 4'b0110, 'h80, 'hFF, "srl_amt_mask");

        // MUL with start held high throughout: ignored while busy, taken right after done
        @(negedge CLK);
        start8 = 1'b1; op8 = 4'b1001; a8 = 8'd3; b8 = 8'd5;
        @(posedge CLK); #1;
        op8 = 4'b0001; a8 = 8'd1; b8 = 8'd2;
        d1 = -1; d2 = -1; late = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge CLK); #1;
            if (i == 10) start8 = 1'b0;
            if (done8) begin
                if (d1 < 0) begin d1 = i; chk("held.mul_res", res8, 15); end
                else if (d2 < 0) begin d2 = i; chk("held.add_res", res8, 3); end
                else late++;
            end
        end
        chk("held.mul_lat", d1, 9);
        chk("held.add_edge", d2, 11);
        chk("held.extra_done", late, 0);

        // Async reset in the middle of a 7-step shift
        @(negedge CLK);
        start8 = 1'b1; op8 = 4'b0101; a8 = 8'h01; b8 = 8'd7;
        @(posedge CLK); #1; start8 = 1'b0;
        repeat (3) @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("arst.busy", busy8, 0);
        chk("arst.res", res8, 0);
        chk("arst.flags", {done8, zero8, carry8, ill8}, 0);
        late = 0;
        repeat (8) begin @(posedge CLK); #1; if (done8) late++; end
        chk("arst.no_done", late, 0);
        @(negedge CLK); RESET = 1'b0;
        run_op(8, 4'b0001, 'h12, 'h34, "post_rst_add");

        // Directed W=16
        run_op(16, 4'b0001, 'hFFFF, 1, "w16_add");
        run_op(16, 4'b1001, 'h1234, 'h0056, "w16_mul");
        run_op(16, 4'b0111, 'h8001, 15, "w16_sra15");

        // Randomized both widths
        for (int i = 0; i < 40; i++) begin
            run_op(8, 4'($urandom_range(0, 15)), $urandom_range(0, 255),
                   $urandom_range(0, 255), "rnd8");
            run_op(16, 4'($urandom_range(0, 15)), $urandom_range(0, 65535),
                   $urandom_range(0, 65535), "rnd16");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
